// File: rtl/ppu_bus_pkg.sv
// Shared types and helpers for the PPU bus controller.
// PPU_BUS_PALETTE_EN selects whether the palette RAM and its $3Fxx decode are built.
package ppu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  typedef enum logic {
    REN = 1'b0,
    CPU = 1'b1
  } req_sel_t;

  localparam logic [5:0] PAL_BASE = 6'h3F;

  // The backdrop entries of the sprite palettes ($3F10/14/18/1C) alias the BG ones.
  function automatic logic [4:0] pal_index(input logic [4:0] a);
    pal_index = (a[1:0] == 2'b00) ? {1'b0, a[3:0]} : a;
  endfunction

endpackage

// File: rtl/ppu_bus_ctrl_pal_ram.sv
// 32-entry palette RAM: synchronous write, combinational zero-extended read.
// Only instantiated when PPU_BUS_PALETTE_EN is defined.
module ppu_pal_ram
  import ppu_bus_pkg::*;
#(
  parameter int PAL_W = 6
) (
  input  logic       clk,
  input  logic       we,
  input  logic [4:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata
);

  logic [PAL_W-1:0] mem [0:31];
  logic [4:0]       idx;

  assign idx   = pal_index(addr);
  assign rdata = {{(8-PAL_W){1'b0}}, mem[idx]};

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata[PAL_W-1:0];
    end
  end

endmodule

// File: rtl/ppu_bus_ctrl.sv
// Two-cycle PPU bus initiator arbitrating render fetches over CPU $2007 accesses.
// Owns CIRAM; palette RAM exists only when PPU_BUS_PALETTE_EN is defined.
module ppu_bus_ctrl
  import ppu_bus_pkg::*;
#(
  parameter int CIRAM_AW = 11,
  parameter int PAL_W    = 6
) (
  input  logic        clk_ppu,
  input  logic        rst,
  input  logic        ren_req,
  input  logic [13:0] ren_addr,
  output logic        ren_ack,
  output logic        ren_rvalid,
  output logic [7:0]  ren_rdata,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [13:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic        cpu_rvalid,
  output logic [7:0]  cpu_rdata,
  output logic [13:0] ppu_addr,
  output logic [7:0]  ppu_wdata,
  input  logic [7:0]  ppu_rdata,
  output logic        ppu_rd,
  output logic        ppu_wr,
  input  logic        ciram_ce,
  input  logic        ciram_a10,
  output logic        busy
);

  state_t              state, next_state;
  req_sel_t            cur_sel;
  logic                cur_we;
  logic                accept, pick_ren;
  logic                is_pal, ciram_we, pal_we;
  logic [7:0]          rd_mux, pal_rdata;
  logic [CIRAM_AW-1:0] ciram_idx;
  logic [7:0]          ciram [0:(2**CIRAM_AW)-1];

  assign pick_ren  = ren_req;
  assign accept    = ((state == IDLE) || (state == DATA)) && (ren_req || cpu_req);
  assign ciram_idx = {ciram_a10, ppu_addr[CIRAM_AW-2:0]};

`ifdef PPU_BUS_PALETTE_EN
  assign is_pal = (ppu_addr[13:8] == PAL_BASE);

  ppu_pal_ram #(.PAL_W(PAL_W)) u_pal (
    .clk   (clk_ppu),
    .we    (pal_we),
    .addr  (ppu_addr[4:0]),
    .wdata (ppu_wdata),
    .rdata (pal_rdata)
  );
`else
  logic [PAL_W:0] unused_pal;
  assign is_pal     = 1'b0;
  assign pal_rdata  = 8'h00;
  assign unused_pal = {{PAL_W{1'b0}}, pal_we};
`endif

  always_ff @(posedge clk_ppu or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE:    next_state = accept ? ADDR : IDLE;
      ADDR:    next_state = DATA;
      DATA:    next_state = accept ? ADDR : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Read source and RAM write enables for the access currently in DATA.
  always_comb begin
    rd_mux   = ppu_rdata;
    pal_we   = 1'b0;
    ciram_we = 1'b0;
    if (is_pal) begin
      rd_mux = pal_rdata;
    end else if (ciram_ce) begin
      rd_mux = ciram[ciram_idx];
    end else begin
      rd_mux = ppu_rdata;
    end
    if ((state == DATA) && cur_we) begin
      pal_we   = is_pal;
      ciram_we = !is_pal && ciram_ce;
    end else begin
      pal_we   = 1'b0;
      ciram_we = 1'b0;
    end
  end

  always_ff @(posedge clk_ppu) begin
    if (ciram_we) begin
      ciram[ciram_idx] <= ppu_wdata;
    end
  end

  // Strobes are set on the ADDR->DATA edge so they cover exactly the DATA cycle.
  always_ff @(posedge clk_ppu or posedge rst) begin
    if (rst) begin
      ren_ack    <= 1'b0;
      cpu_ack    <= 1'b0;
      ren_rvalid <= 1'b0;
      cpu_rvalid <= 1'b0;
      ren_rdata  <= 8'h00;
      cpu_rdata  <= 8'h00;
      ppu_addr   <= 14'h0000;
      ppu_wdata  <= 8'h00;
      ppu_rd     <= 1'b0;
      ppu_wr     <= 1'b0;
      busy       <= 1'b0;
      cur_sel    <= REN;
      cur_we     <= 1'b0;
    end else begin
      ren_ack <= accept && pick_ren;
      cpu_ack <= accept && !pick_ren;
      if (accept) begin
        ppu_addr <= pick_ren ? ren_addr : cpu_addr;
        cur_sel  <= pick_ren ? REN : CPU;
        cur_we   <= !pick_ren && cpu_we;
        if (!pick_ren) begin
          ppu_wdata <= cpu_wdata;
        end
      end
      ppu_rd     <= (state == ADDR) && !cur_we && !is_pal;
      ppu_wr     <= (state == ADDR) && cur_we && !is_pal;
      busy       <= (next_state != IDLE);
      ren_rvalid <= (state == DATA) && (cur_sel == REN) && !cur_we;
      cpu_rvalid <= (state == DATA) && (cur_sel == CPU) && !cur_we;
      if ((state == DATA) && (cur_sel == REN) && !cur_we) begin
        ren_rdata <= rd_mux;
      end
      if ((state == DATA) && (cur_sel == CPU) && !cur_we) begin
        cpu_rdata <= rd_mux;
      end
    end
  end

endmodule

// File: tb/tb_ppu_bus_ctrl.sv
// Directed, table-driven bench for ppu_bus_ctrl; honours PPU_BUS_PALETTE_EN.
module tb_ppu_bus_ctrl;

`ifdef PPU_BUS_PALETTE_EN
  localparam bit PAL_ON = 1'b1;
`else
  localparam bit PAL_ON = 1'b0;
`endif

  logic        clk_ppu = 1'b0;
  logic        rst = 1'b1;
  logic        ren_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0;
  logic [13:0] ren_addr = 14'h0000, cpu_addr = 14'h0000;
  logic [7:0]  cpu_wdata = 8'h00;
  logic        ciram_ce = 1'b0, ciram_a10 = 1'b0;
  logic        ren_ack, ren_rvalid, cpu_ack, cpu_rvalid, ppu_rd, ppu_wr, busy;
  logic [7:0]  ren_rdata, cpu_rdata, ppu_wdata, ppu_rdata;
  logic [13:0] ppu_addr;

  int tests = 0;
  int fails = 0;

  // Cartridge model: open CHR returns the low address byte.
  assign ppu_rdata = ppu_addr[7:0];

  always #5 clk_ppu = ~clk_ppu;

  ppu_bus_ctrl dut (
    .clk_ppu(clk_ppu), .rst(rst),
    .ren_req(ren_req), .ren_addr(ren_addr), .ren_ack(ren_ack),
    .ren_rvalid(ren_rvalid), .ren_rdata(ren_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ppu_addr(ppu_addr), .ppu_wdata(ppu_wdata), .ppu_rdata(ppu_rdata),
    .ppu_rd(ppu_rd), .ppu_wr(ppu_wr), .ciram_ce(ciram_ce), .ciram_a10(ciram_a10),
    .busy(busy)
  );

  typedef struct {
    logic        cpu;
    logic        we;
    logic [13:0] addr;
    logic [7:0]  wd;
    logic        ce;
    logic        a10;
    logic [7:0]  exp_on;
    logic [7:0]  exp_off;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int ack_at = -1, rv_at = -1, strobe_at = -1, wr_n = 0, rd_n = 0, bad = 0;
    logic [7:0]  rdv = 8'h00, s_wd = 8'h00;
    logic [13:0] s_addr = 14'h0000;
    logic        pal;
    string       tag;
    pal = PAL_ON && (v.addr[13:8] == 6'h3F);
    tag = $sformatf("vec%0d", id);
    ciram_ce  = v.ce;
    ciram_a10 = v.a10;
    if (v.cpu) begin
      cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wd;
    end else begin
      ren_req = 1'b1; ren_addr = v.addr;
    end
    for (int t = 1; t <= 6; t++) begin
      @(posedge clk_ppu); #1;
      if (v.cpu ? cpu_ack : ren_ack) begin
        if (ack_at < 0) ack_at = t;
        cpu_req = 1'b0; ren_req = 1'b0;
      end
      if (v.cpu ? ren_ack : cpu_ack) bad++;
      if (v.cpu ? cpu_rvalid : ren_rvalid) begin
        rv_at = t; rdv = v.cpu ? cpu_rdata : ren_rdata;
      end
      if (v.cpu ? ren_rvalid : cpu_rvalid) bad++;
      if (ppu_wr) begin wr_n++; strobe_at = t; s_addr = ppu_addr; s_wd = ppu_wdata; end
      if (ppu_rd) begin rd_n++; strobe_at = t; s_addr = ppu_addr; end
      if ((ppu_rd && ppu_wr) || ((ppu_rd || ppu_wr) && !busy)) bad++;
    end
    chk({tag, " ack_cycle"}, ack_at, 1);
    chk({tag, " rvalid_cycle"}, rv_at, v.we ? -1 : 3);
    if (!v.we) chk({tag, " rdata"}, int'(rdv), int'(PAL_ON ? v.exp_on : v.exp_off));
    chk({tag, " wr_pulses"}, wr_n, (v.we && !pal) ? 1 : 0);
    chk({tag, " rd_pulses"}, rd_n, (!v.we && !pal) ? 1 : 0);
    chk({tag, " protocol"}, bad, 0);
    if (!pal) begin
      chk({tag, " strobe_cycle"}, strobe_at, 2);
      chk({tag, " strobe_addr"}, int'(s_addr), int'(v.addr));
      if (v.we) chk({tag, " strobe_wdata"}, int'(s_wd), int'(v.wd));
    end
  endtask

  vec_t vecs[14];

  initial begin
    int ack_t[4], rv_t[4];
    logic [7:0] rv_d[4];
    int n_ack, n_rv, ren_a, cpu_a, cpu_rv, rv_seen;
    vec_t fresh;

    vecs[0]  = '{1'b1, 1'b1, 14'h2005, 8'hA5, 1'b1, 1'b0, 8'h00, 8'h00};
    vecs[1]  = '{1'b1, 1'b1, 14'h2005, 8'h5A, 1'b1, 1'b1, 8'h00, 8'h00};
    vecs[2]  = '{1'b0, 1'b0, 14'h2005, 8'h00, 1'b1, 1'b0, 8'hA5, 8'hA5};
    vecs[3]  = '{1'b0, 1'b0, 14'h2005, 8'h00, 1'b1, 1'b1, 8'h5A, 8'h5A};
    vecs[4]  = '{1'b1, 1'b0, 14'h2005, 8'h00, 1'b1, 1'b0, 8'hA5, 8'hA5};
    vecs[5]  = '{1'b0, 1'b0, 14'h0123, 8'h00, 1'b0, 1'b0, 8'h23, 8'h23};
    vecs[6]  = '{1'b1, 1'b0, 14'h0ABC, 8'h00, 1'b0, 1'b0, 8'hBC, 8'hBC};
    vecs[7]  = '{1'b1, 1'b1, 14'h3F10, 8'hFF, 1'b0, 1'b0, 8'h00, 8'h00};
    vecs[8]  = '{1'b1, 1'b0, 14'h3F00, 8'h00, 1'b0, 1'b0, 8'h3F, 8'h00};
    vecs[9]  = '{1'b1, 1'b1, 14'h3F11, 8'h15, 1'b0, 1'b0, 8'h00, 8'h00};
    vecs[10] = '{1'b0, 1'b0, 14'h3F11, 8'h00, 1'b0, 1'b0, 8'h15, 8'h11};
    vecs[11] = '{1'b0, 1'b0, 14'h3FF0, 8'h00, 1'b0, 1'b0, 8'h3F, 8'hF0};
    vecs[12] = '{1'b1, 1'b1, 14'h2C07, 8'h3C, 1'b1, 1'b1, 8'h00, 8'h00};
    vecs[13] = '{1'b0, 1'b0, 14'h2C07, 8'h00, 1'b1, 1'b1, 8'h3C, 8'h3C};

    repeat (2) @(posedge clk_ppu);
    #1;
    chk("reset ppu_addr", int'(ppu_addr), 0);
    chk("reset strobes", int'({ppu_rd, ppu_wr, busy}), 0);
    chk("reset acks_rvalids", int'({ren_ack, cpu_ack, ren_rvalid, cpu_rvalid}), 0);
    chk("reset rdata", int'({ren_rdata, cpu_rdata, ppu_wdata}), 0);
    rst = 1'b0;
    @(posedge clk_ppu); #1;

    for (int i = 0; i < 14; i++) begin
      run_vec(i, vecs[i]);
    end

    // Back-to-back render fetches with the request held high.
    n_ack = 0; n_rv = 0; ciram_ce = 1'b0;
    ren_req = 1'b1; ren_addr = 14'h0010;
    for (int t = 1; t <= 11; t++) begin
      @(posedge clk_ppu); #1;
      if (ren_ack && n_ack < 4) begin
        ack_t[n_ack] = t; n_ack++;
        if (n_ack < 4) ren_addr = 14'h0010 + 14'(n_ack);
        else ren_req = 1'b0;
      end
      if (ren_rvalid && n_rv < 4) begin
        rv_t[n_rv] = t; rv_d[n_rv] = ren_rdata; n_rv++;
      end
    end
    ren_req = 1'b0;
    chk("b2b ack_count", n_ack, 4);
    chk("b2b rvalid_count", n_rv, 4);
    for (int i = 0; i < 4; i++) begin
      if (i < n_ack) chk($sformatf("b2b ack%0d_cycle", i), ack_t[i], 1 + 2 * i);
      if (i < n_rv) begin
        chk($sformatf("b2b rv%0d_cycle", i), rv_t[i], 3 + 2 * i);
        chk($sformatf("b2b rv%0d_data", i), int'(rv_d[i]), 16 + i);
      end
    end

    // Simultaneous requests: render wins, CPU follows two cycles later.
    ren_a = -1; cpu_a = -1; cpu_rv = -1;
    ren_req = 1'b1; ren_addr = 14'h0001;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0002;
    for (int t = 1; t <= 8; t++) begin
      @(posedge clk_ppu); #1;
      if (ren_ack && ren_a < 0) begin ren_a = t; ren_req = 1'b0; end
      if (cpu_ack && cpu_a < 0) begin cpu_a = t; cpu_req = 1'b0; end
      if (cpu_rvalid && cpu_rv < 0) begin
        cpu_rv = t; chk("simul cpu_rdata", int'(cpu_rdata), 2);
      end
    end
    ren_req = 1'b0; cpu_req = 1'b0;
    chk("simul ren_ack_cycle", ren_a, 1);
    chk("simul cpu_ack_cycle", cpu_a, 3);
    chk("simul cpu_rvalid_cycle", cpu_rv, 5);

    // Reset asserted while the access sits in ADDR.
    ren_req = 1'b1; ren_addr = 14'h0077;
    @(posedge clk_ppu); #1;
    chk("rst_mid in_addr_busy", int'(busy), 1);
    ren_req = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_mid ppu_addr", int'(ppu_addr), 0);
    chk("rst_mid outputs", int'({busy, ren_ack, ppu_rd, ppu_wr}), 0);
    rv_seen = 0;
    for (int t = 0; t < 6; t++) begin
      @(posedge clk_ppu); #1;
      if (ren_rvalid || cpu_rvalid || ppu_rd) rv_seen++;
      if (t == 2) rst = 1'b0;
    end
    chk("rst_mid no_rvalid", rv_seen, 0);
    fresh = '{1'b0, 1'b0, 14'h0155, 8'h00, 1'b0, 1'b0, 8'h55, 8'h55};
    run_vec(99, fresh);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, limit 200000 ns");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ppu_bus_ctrl.md
Name: ppu_bus_ctrl

Overview:
- Console-side initiator for the cartridge PPU bus.
- Arbitrates rendering fetches and CPU $2007 accesses onto one 14-bit PPU address space.
- Runs each access as a 2-cycle address/data transaction on the cart PPU pins.
- Owns the 2 KB nametable CIRAM, whose select and A10 come from the cartridge, and the 32-entry palette RAM.

Parameters:
- CIRAM_AW, 11, CIRAM address width (2**CIRAM_AW bytes).
- PAL_W, 6, palette entry width in bits.

Ports:
- clk_ppu  in  1  PPU clock; sole clock.
- rst  in  1  asynchronous, active-high reset.
- ren_req  in  1  render fetch request; hold until ren_ack.
- ren_addr  in  14  render fetch address.
- ren_ack  out  1  1-cycle pulse: render request accepted.
- ren_rvalid  out  1  1-cycle pulse: ren_rdata valid.
- ren_rdata  out  8  render read data.
- cpu_req  in  1  CPU ($2007) request; hold until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  14  CPU access address.
- cpu_wdata  in  8  CPU write data.
- cpu_ack  out  1  1-cycle pulse: CPU request accepted.
- cpu_rvalid  out  1  1-cycle pulse: cpu_rdata valid (reads only).
- cpu_rdata  out  8  CPU read data.
- ppu_addr  out  14  address to cartridge.
- ppu_wdata  out  8  write data to cartridge.
- ppu_rdata  in  8  read data from cartridge (combinational on ppu_addr).
- ppu_rd  out  1  cartridge read strobe.
- ppu_wr  out  1  cartridge write strobe.
- ciram_ce  in  1  from cartridge: 1 = CIRAM selected for current ppu_addr.
- ciram_a10  in  1  from cartridge: CIRAM A10 for current ppu_addr.
- busy  out  1  high in ADDR or DATA.

Behaviour:
- Reset (async, rst=1):
  - FSM goes to IDLE.
  - Outputs cleared: ppu_addr=0, ppu_wdata=0, ppu_rd=0, ppu_wr=0, acks=0, rvalids=0, rdata=0, busy=0.
  - CIRAM and palette contents are not cleared.
  - Reset mid-transaction aborts it: no ack, no rvalid is produced for it.
- FSM states:
  - IDLE: accept a request if any.
  - ADDR: ppu_addr driven and stable; rd/wr low.
  - DATA: ppu_rd (read) or ppu_wr (write) high for exactly this cycle; read data sampled at the end of the cycle.
- Acceptance:
  - Requests are accepted only in IDLE or DATA.
  - Accept at edge k: the ack pulses high during k+1, ppu_addr is registered, and the state becomes ADDR.
  - DATA occupies k+2. rvalid and rdata are registered at the end of k+2 and valid during k+3.
  - From DATA, a pending request goes straight to ADDR (one access per 2 cycles sustained). With no request pending, DATA goes to IDLE.
- Arbitration: fixed priority, render over CPU. Simultaneous requests: render is served first; CPU waits with cpu_req held.
- Write-only CPU accesses produce no cpu_rvalid. ppu_wdata = cpu_wdata, latched at accept.
- Read routing (in DATA, priority order):
  1. Palette: ppu_addr[13:8]==6'h3F → palette RAM. ppu_rd stays low.
  2. CIRAM: ciram_ce=1 → CIRAM[{ciram_a10, ppu_addr[CIRAM_AW-2:0]}]. ppu_rd is still asserted.
  3. Otherwise → ppu_rdata.
- Write routing:
  - Palette region: palette RAM only, ppu_wr low.
  - Otherwise: ppu_wr asserted. CIRAM is also written when ciram_ce=1, so cartridge CHR-RAM still sees every write.
- Palette details:
  - Index = addr[4:0]. If index[1:0]==0, bit 4 is cleared, so $3F10/14/18/1C alias $3F00/04/08/0C.
  - Stored width is PAL_W bits; writes are truncated to it.
  - Reads return the entry zero-extended to 8 bits.
  - Mirroring is decoded over the full $3F00-$3FFF range.
- ciram_ce and ciram_a10 are sampled in DATA; the cart decodes them combinationally from the stable ppu_addr.
- ppu_addr holds its last value in IDLE. ppu_rd and ppu_wr are never high outside DATA and never high together.

Optional Feature:
- Macro: PPU_BUS_PALETTE_EN.
- Defined: palette RAM and $3Fxx decode present as above.
- Undefined: no palette RAM. $3Fxx accesses are treated like any other address (CIRAM or cart, with strobes asserted). The PAL_W parameter is unused.

Decomposition:
- Package ppu_bus_pkg contains:
  - the state enum (IDLE, ADDR, DATA);
  - the requester-select enum (REN, CPU);
  - PAL_BASE=6'h3F;
  - the palette index-mirror function.
- One sub-module: ppu_pal_ram (32xPAL_W, synchronous write, combinational read, mirrored indexing), instantiated under the macro.

Test Plan:
- CIRAM round trip: CPU write $2005=0xA5 with cart ciram_ce=1, ciram_a10=0; then render read $2005. Required: ppu_wr high 1 cycle, ren_rvalid on cycle 3 after accept, ren_rdata=0xA5. With ciram_a10=1, the same read returns independent data.
- Cart read: render read $0123 with ciram_ce=0 and ppu_rdata model = addr[7:0]. Required: ren_rdata=0x23, ppu_rd high only in DATA.
- Back-to-back render requests: 4 consecutive requests issued. Required: acks at cycles 1,3,5,7 and 4 rvalids spaced 2 cycles apart.
- Simultaneous ren_req and cpu_req in IDLE. Required: ren_ack first, cpu_ack exactly 2 cycles later.
- Palette (macro on): CPU write $3F10=0xFF, then read $3F00. Required: 0x3F returned, ppu_wr never asserted. With macro off, the same write asserts ppu_wr.
- Reset mid-access: assert rst during ADDR. Required: outputs zero immediately, no rvalid; a fresh request after release completes normally.
